// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one combinational ALU
// Commands are latched on grant, executed for one cycle, and held on a backpressured response port.

module alu_arbiter_alu #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   operation,
  output logic [DATA_W:0]   z
);

  always_comb begin
    z = '0;
    case (operation)
      OP_W'(0): z = {1'b0, a} + {1'b0, b};
      OP_W'(1): z = {1'b0, a} - {1'b0, b};
      OP_W'(2): z = {1'b0, a & b};
      default:  z = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int                     DATA_W        = 8,
  parameter int                     OP_W          = 4,
  parameter logic [(2**OP_W)-1:0]   LEGAL_OP_MASK = 16'h0007
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W:0]   rsp_z,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              pref;
  logic              grant_valid, grant_id, accept;
  logic [DATA_W-1:0] sel_a, sel_b, lat_a, lat_b;
  logic [OP_W-1:0]   sel_op, lat_op;
  logic              lat_id, lat_err;
  logic [DATA_W:0]   alu_z;

  // pref names the requester that wins a tie; it flips only when a response completes
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!pref) begin
      if (req0_valid) begin
        grant_valid = 1'b1;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end else begin
      if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
      end
    end
  end

  assign accept     = (state == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign busy       = (state != IDLE);

  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign sel_op = grant_id ? req1_op : req0_op;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  alu_arbiter_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a         (lat_a),
    .b         (lat_b),
    .operation (lat_op),
    .z         (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref      <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      lat_id    <= 1'b0;
      lat_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_a   <= sel_a;
          lat_b   <= sel_b;
          lat_op  <= sel_op;
          lat_id  <= grant_id;
          lat_err <= ~LEGAL_OP_MASK[sel_op];
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_z     <= lat_err ? '0 : alu_z;
          rsp_id    <= lat_id;
          rsp_err   <= lat_err;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          pref      <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a behavioural model

module tb_alu_arbiter;

  localparam logic [15:0] LEGAL = 16'h0007;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [8:0] rsp_z;

  int checks   = 0;
  int failures = 0;
  bit pref_m   = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_z(input int op, input int a, input int b);
    if (((LEGAL >> op) & 16'd1) == 16'd0) return 0;
    case (op)
      0:       return a + b;
      1:       return (a - b) & 511;
      2:       return a & b;
      default: return 0;
    endcase
  endfunction

  // Starts just after a rising edge with the DUT idle; returns at the same phase, idle again.
  task automatic txn(input bit v0, input int a0, input int b0, input int op0,
                     input bit v1, input int a1, input int b1, input int op1,
                     input int stall);
    int id, op, ez;
    bit eerr;
    req0_valid = v0; req0_a = 8'(a0); req0_b = 8'(b0); req0_op = 4'(op0);
    req1_valid = v1; req1_a = 8'(a1); req1_b = 8'(b1); req1_op = 4'(op1);
    rsp_ready  = (stall == 0);
    id   = pref_m ? (v1 ? 1 : 0) : (v0 ? 0 : 1);
    op   = id ? op1 : op0;
    ez   = id ? model_z(op1, a1, b1) : model_z(op0, a0, b0);
    eerr = ((LEGAL >> op) & 16'd1) == 16'd0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_ready0", req0_ready, id == 0);
    check("idle_ready1", req1_ready, id == 1);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_readys", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_z", rsp_z, ez);
    check("rsp_id", rsp_id, id);
    check("rsp_err", rsp_err, eerr);
    check("rsp_readys", {req0_ready, req1_ready}, 0);
    check("rsp_busy", busy, 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_z", rsp_z, ez);
      check("stall_id", rsp_id, id);
      check("stall_readys", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    pref_m = (id == 0);
  endtask

  task automatic reset_mid(input bit at_resp);
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9; req0_op = 4'd0;
    rsp_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    if (at_resp) begin
      @(posedge clk); #1;
      check("pre_rst_rsp_valid", rsp_valid, 1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_rsp_err", rsp_err, 0);
    pref_m = 1'b0;
    #3 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_z", rsp_z, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_busy", busy, 0);
    check("reset_readys", {req0_ready, req1_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1, 240, 15, 0, 0, 0, 0, 0, 0);
    check("first_pref_moved", pref_m, 1);

    txn(0, 0, 0, 0, 1, 255, 255, 0, 0);
    txn(0, 0, 0, 0, 1, 240, 15, 1, 0);
    txn(0, 0, 0, 0, 1, 240, 15, 2, 0);

    for (int k = 0; k < 4; k++) begin
      txn(1, 1, 2, 0, 1, 3, 4, 0, 0);
      check("contention_id", rsp_id, k % 2);
    end

    txn(1, 7, 9, 0, 0, 0, 0, 0, 10);
    txn(1, 5, 5, 4'b1010, 0, 0, 0, 0, 0);

    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_no_grant", {req0_ready, req1_ready}, 0);
      check("idle_no_busy", busy, 0);
    end

    txn(1, 1, 1, 0, 0, 0, 0, 0, 0);
    reset_mid(1'b0);
    txn(1, 100, 27, 1, 1, 50, 60, 0, 0);
    check("rst_exec_prio", rsp_id, 0);

    txn(1, 1, 1, 0, 0, 0, 0, 0, 0);
    reset_mid(1'b1);
    txn(1, 200, 100, 0, 1, 50, 60, 2, 0);
    check("rst_resp_prio", rsp_id, 0);

    for (int n = 0; n < 24; n++) begin
      bit v0, v1;
      int o0, o1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
      o1 = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
      txn(v0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), o0,
          v1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), o1,
          int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
